// File: rtl/inv_unit_pkg.sv
// Shared constants and types for the bitwise inverter block.
package inv_unit_pkg;

    localparam int INV_WIDTH_DEFAULT = 4;

    typedef logic [INV_WIDTH_DEFAULT-1:0] inv_data_t;

endpackage

// File: rtl/inv_unit_comb.sv
// Pure bitwise inversion; shared by the combinational and registered views.
module inv_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a;

endmodule

// File: rtl/inv_unit.sv
// Bitwise inverter with a zero-latency view and a one-cycle registered view.
// y_q holds its last capture between in_valid pulses; out_valid marks fresh data.
module inv_unit
    import inv_unit_pkg::*;
#(
    parameter int WIDTH = INV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             y_all_ones,
    output logic             y_all_zero
);

    logic [WIDTH-1:0] y_inv;

    inv_comb #(.WIDTH(WIDTH)) u_inv_comb (
        .a (a),
        .y (y_inv)
    );

    assign y          = y_inv;
    assign y_all_ones = &y_inv;
    assign y_all_zero = ~|y_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q <= y_inv;
            end
        end
    end

endmodule

// File: tb/tb_inv_unit.sv
// Directed self-checking bench for inv_unit at WIDTH=4 plus a WIDTH=8 instance.
module tb_inv_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic       in_valid;
    logic [3:0] y;
    logic [3:0] y_q;
    logic       out_valid;
    logic       y_all_ones;
    logic       y_all_zero;

    logic [7:0] a8;
    logic       in_valid8;
    logic [7:0] y8;
    logic [7:0] y_q8;
    logic       out_valid8;
    logic       y_all_ones8;
    logic       y_all_zero8;

    int checks;
    int passes;

    inv_unit #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .in_valid   (in_valid),
        .y          (y),
        .y_q        (y_q),
        .out_valid  (out_valid),
        .y_all_ones (y_all_ones),
        .y_all_zero (y_all_zero)
    );

    inv_unit #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a8),
        .in_valid   (in_valid8),
        .y          (y8),
        .y_q        (y_q8),
        .out_valid  (out_valid8),
        .y_all_ones (y_all_ones8),
        .y_all_zero (y_all_zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        a         = 4'b0000;
        in_valid  = 1'b0;
        a8        = 8'h00;
        in_valid8 = 1'b0;
        #12;
        checks++;
        if (y_q !== 4'b0000) $display("[TB] FAIL reset_y_q got %b want 0000", y_q);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        else passes++;
        checks++;
        if (y !== 4'b1111) $display("[TB] FAIL reset_y got %b want 1111", y);
        else passes++;
        checks++;
        if (y_q8 !== 8'h00 || out_valid8 !== 1'b0)
            $display("[TB] FAIL reset_w8 got y_q=%h ov=%b want 00/0", y_q8, out_valid8);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb_sweep();
        logic [3:0] want [16] = '{4'b1111, 4'b1110, 4'b1101, 4'b1100,
                                  4'b1011, 4'b1010, 4'b1001, 4'b1000,
                                  4'b0111, 4'b0110, 4'b0101, 4'b0100,
                                  4'b0011, 4'b0010, 4'b0001, 4'b0000};
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #10;
            checks++;
            if (y !== want[i]) $display("[TB] FAIL sweep_a%0d got %b want %b", i, y, want[i]);
            else passes++;
        end
    endtask

    task automatic test_patterns();
        logic [3:0] pat_a    [5] = '{4'b1010, 4'b0101, 4'b0000, 4'b1111, 4'b0011};
        logic [3:0] pat_y    [5] = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b1100};
        logic       pat_ones [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       pat_zero [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            a = pat_a[i];
            #3;
            checks++;
            if (y !== pat_y[i] || y_all_ones !== pat_ones[i] || y_all_zero !== pat_zero[i])
                $display("[TB] FAIL pattern_%b got y=%b ones=%b zero=%b want y=%b ones=%b zero=%b",
                         pat_a[i], y, y_all_ones, y_all_zero, pat_y[i], pat_ones[i], pat_zero[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] in_a  [3] = '{4'b0001, 4'b0010, 4'b0100};
        logic [3:0] exp_q [3] = '{4'b1110, 4'b1101, 4'b1011};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a        = in_a[i];
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (y_q !== exp_q[i] || out_valid !== 1'b1)
                $display("[TB] FAIL pipe_%0d got y_q=%b ov=%b want %b/1", i, y_q, out_valid, exp_q[i]);
            else passes++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || y_q !== 4'b1011)
            $display("[TB] FAIL pipe_end got y_q=%b ov=%b want 1011/0", y_q, out_valid);
        else passes++;
    endtask

    task automatic test_hold();
        a        = 4'b1100;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (y_q !== 4'b0011 || out_valid !== 1'b1)
            $display("[TB] FAIL hold_capture got y_q=%b ov=%b want 0011/1", y_q, out_valid);
        else passes++;
        in_valid = 1'b0;
        a        = 4'b1111;
        #1;
        checks++;
        if (y !== 4'b0000) $display("[TB] FAIL hold_y_tracks got %b want 0000", y);
        else passes++;
        @(negedge clk);
        checks++;
        if (y_q !== 4'b0011 || out_valid !== 1'b0)
            $display("[TB] FAIL hold_keep got y_q=%b ov=%b want 0011/0", y_q, out_valid);
        else passes++;
    endtask

    task automatic test_async_reset();
        a        = 4'b1100;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (y_q !== 4'b0011 || out_valid !== 1'b1)
            $display("[TB] FAIL arst_pre got y_q=%b ov=%b want 0011/1", y_q, out_valid);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y_q !== 4'b0000 || out_valid !== 1'b0)
            $display("[TB] FAIL arst_clear got y_q=%b ov=%b want 0000/0", y_q, out_valid);
        else passes++;
        checks++;
        if (y !== 4'b0011) $display("[TB] FAIL arst_y got %b want 0011", y);
        else passes++;
        #1;
        rst_n = 1'b1;
        a     = 4'b1001;
        @(negedge clk);
        checks++;
        if (y_q !== 4'b0110 || out_valid !== 1'b1)
            $display("[TB] FAIL arst_first_capture got y_q=%b ov=%b want 0110/1", y_q, out_valid);
        else passes++;
        in_valid = 1'b0;
    endtask

    task automatic test_width8();
        a8        = 8'hA5;
        in_valid8 = 1'b1;
        #1;
        checks++;
        if (y8 !== 8'h5A || y_all_ones8 !== 1'b0 || y_all_zero8 !== 1'b0)
            $display("[TB] FAIL w8_comb got y=%h ones=%b zero=%b want 5a/0/0", y8, y_all_ones8, y_all_zero8);
        else passes++;
        @(negedge clk);
        checks++;
        if (y_q8 !== 8'h5A || out_valid8 !== 1'b1)
            $display("[TB] FAIL w8_reg got y_q=%h ov=%b want 5a/1", y_q8, out_valid8);
        else passes++;
        a8        = 8'hFF;
        in_valid8 = 1'b0;
        #1;
        checks++;
        if (y8 !== 8'h00 || y_all_zero8 !== 1'b1 || y_all_ones8 !== 1'b0)
            $display("[TB] FAIL w8_flags got y=%h ones=%b zero=%b want 00/0/1", y8, y_all_ones8, y_all_zero8);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_comb_sweep();
        test_patterns();
        test_back_to_back();
        test_hold();
        test_async_reset();
        test_width8();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
